// File: rtl/conv_config_streamer.sv
// rtl/conv_config_streamer.sv - host-written config register file streamed as {adr,data} beats
// Optional macro CFG_CHECKSUM_EN appends an XOR checksum beat {NUM_ENTRIES, xor} to each stream.
module conv_config_streamer #(
  parameter int CONFIG_ADDR_WIDTH = 8,
  parameter int CONFIG_DATA_WIDTH = 8,
  parameter int NUM_ENTRIES       = 35
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         host_wr_en,
  input  logic [CONFIG_ADDR_WIDTH-1:0]                 host_wr_adr,
  input  logic [CONFIG_DATA_WIDTH-1:0]                 host_wr_data,
  input  logic                                         start,
  input  logic [CONFIG_ADDR_WIDTH-1:0]                 cfg_first,
  input  logic [CONFIG_ADDR_WIDTH-1:0]                 cfg_last,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         err,
  output logic [CONFIG_ADDR_WIDTH+CONFIG_DATA_WIDTH-1:0] config_data,
  output logic                                         config_vld,
  input  logic                                         config_rdy
);

  localparam int CAW = CONFIG_ADDR_WIDTH;
  localparam int CDW = CONFIG_DATA_WIDTH;
  localparam int IW  = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [CAW:0] NUM_EXT = (CAW+1)'(NUM_ENTRIES);

`ifdef CFG_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, STREAM, CSUM} state_t;
`else
  typedef enum logic [0:0] {IDLE, STREAM} state_t;
`endif

  state_t               state_q, state_d;
  logic [CDW-1:0]       mem_q [NUM_ENTRIES];
  logic [CDW-1:0]       mem_d [NUM_ENTRIES];
  logic [CAW-1:0]       idx_q, idx_d, last_q, last_d, idx_nxt;
  logic [CAW+CDW-1:0]   data_q, data_d;
  logic                 vld_q, vld_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                 range_ok;
`ifdef CFG_CHECKSUM_EN
  logic [CDW-1:0]       xor_q, xor_d;
`endif

  assign range_ok = (cfg_first <= cfg_last) && ({1'b0, cfg_last} < NUM_EXT);
  assign idx_nxt  = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    idx_d   = idx_q;
    last_d  = last_q;
    data_d  = data_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef CFG_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      IDLE: begin
        // A start always takes priority: a same-cycle host write is dropped.
        if (start) begin
          if (range_ok) begin
            state_d = STREAM;
            idx_d   = cfg_first;
            last_d  = cfg_last;
            data_d  = {cfg_first, mem_q[cfg_first[IW-1:0]]};
            vld_d   = 1'b1;
            busy_d  = 1'b1;
`ifdef CFG_CHECKSUM_EN
            xor_d   = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end else if (host_wr_en && ({1'b0, host_wr_adr} < NUM_EXT)) begin
          mem_d[host_wr_adr[IW-1:0]] = host_wr_data;
        end
      end
      STREAM: begin
        if (vld_q && config_rdy) begin
`ifdef CFG_CHECKSUM_EN
          xor_d = xor_q ^ data_q[CDW-1:0];
`endif
          if (idx_q == last_q) begin
`ifdef CFG_CHECKSUM_EN
            state_d = CSUM;
            data_d  = {CAW'(NUM_ENTRIES), xor_q ^ data_q[CDW-1:0]};
`else
            state_d = IDLE;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end else begin
            idx_d  = idx_nxt;
            data_d = {idx_nxt, mem_q[idx_nxt[IW-1:0]]};
          end
        end
      end
`ifdef CFG_CHECKSUM_EN
      CSUM: begin
        if (config_rdy) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_ENTRIES; i++) mem_q[i] <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef CFG_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign config_data = data_q;
  assign config_vld  = vld_q;

endmodule

// File: tb/tb_conv_config_streamer.sv
// tb/tb_conv_config_streamer.sv - directed plus randomized self-checking bench for conv_config_streamer
// Expected beats come from an array model of the register file and the streaming rules.
module tb_conv_config_streamer;

  localparam int NE = 35;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_wr_en = 1'b0;
  logic [7:0]  host_wr_adr = '0;
  logic [7:0]  host_wr_data = '0;
  logic        start = 1'b0;
  logic [7:0]  cfg_first = '0;
  logic [7:0]  cfg_last = '0;
  logic        busy, done, err, config_vld;
  logic [15:0] config_data;
  logic        config_rdy = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [7:0] model [NE];

  conv_config_streamer #(.CONFIG_ADDR_WIDTH(8), .CONFIG_DATA_WIDTH(8), .NUM_ENTRIES(NE)) dut (
    .clk(clk), .rst_n(rst_n), .host_wr_en(host_wr_en), .host_wr_adr(host_wr_adr),
    .host_wr_data(host_wr_data), .start(start), .cfg_first(cfg_first), .cfg_last(cfg_last),
    .busy(busy), .done(done), .err(err), .config_data(config_data), .config_vld(config_vld),
    .config_rdy(config_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [7:0] adr, input logic [7:0] data);
    host_wr_en = 1'b1; host_wr_adr = adr; host_wr_data = data;
    @(negedge clk);
    host_wr_en = 1'b0;
    if (adr < NE) model[adr] = data;
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready.
  // junk: hammer host writes at entry 'last' during start and busy; must be ignored.
  task automatic stream(input int first, input int last, input int mode, input bit junk,
                        output int busy_cnt);
    logic [15:0] expq[$];
    logic [15:0] got[$];
    logic [15:0] held;
    logic [7:0]  x;
    bit          stall, r;
    int          done_at, last_acc, pat;
    x = '0;
    for (int i = first; i <= last; i++) begin
      expq.push_back({8'(i), model[i]});
      x ^= model[i];
    end
`ifdef CFG_CHECKSUM_EN
    expq.push_back({8'(NE), x});
`endif
    cfg_first = 8'(first); cfg_last = 8'(last); start = 1'b1;
    if (junk) begin
      host_wr_en = 1'b1; host_wr_adr = 8'(last); host_wr_data = ~model[last];
    end
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_vld", config_vld, 1);
    busy_cnt = 0; done_at = -1; last_acc = -1; pat = 0; stall = 0; held = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done) begin done_at = cyc; break; end
      if (busy) busy_cnt++;
      r = 1'b0;
      if (config_vld) begin
        if (stall) chk("hold", config_data, held);
        case (mode)
          0: r = 1'b1;
          1: r = (pat % 4 == 0) || (pat % 4 == 3);
          default: r = 1'($urandom_range(0, 1));
        endcase
        pat++;
        if (r) begin got.push_back(config_data); last_acc = cyc; end
        stall = !r;
        held  = config_data;
      end
      config_rdy = r;
      @(negedge clk);
    end
    host_wr_en = 1'b0; config_rdy = 1'b0;
    chk("done_seen", 32'(done_at >= 0), 1);
    chk("done_lat", 32'(done_at - last_acc), 1);
    chk("busy_at_done", busy, 0);
    chk("vld_at_done", config_vld, 0);
    chk("nbeats", got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++) chk("beat", got[i], expq[i]);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  task automatic bad_start(input logic [7:0] f, input logic [7:0] l);
    cfg_first = f; cfg_last = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_vld", config_vld, 0);
    @(negedge clk);
    chk("err_clear", err, 0);
    chk("err_vld2", config_vld, 0);
  endtask

  initial begin
    int bc, nb, f, l;
    for (int i = 0; i < NE; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_vld", config_vld, 0);
    chk("rst_data", config_data, 0);
    chk("rst_done_err", {done, err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_vld", config_vld, 0);
    chk("post_rst_busy", busy, 0);

`ifdef CFG_CHECKSUM_EN
    nb = NE + 1;
`else
    nb = NE;
`endif
    for (int i = 0; i < NE; i++) host_write(8'(i), 8'hA0 + 8'(i));
    stream(0, 34, 0, 0, bc);
    chk("busy_cycles", bc, nb);
    stream(0, 34, 1, 0, bc);
    stream(26, 29, 0, 0, bc);
    bad_start(8'd5, 8'd3);
    bad_start(8'd0, 8'd35);
    bad_start(8'd35, 8'd35);

    stream(0, 7, 1, 1, bc);
    stream(7, 7, 0, 0, bc);
    stream(3, 10, 0, 1, bc);
    host_write(8'd40, 8'h5A);
    host_write(8'd67, 8'hC3);
    stream(0, 34, 2, 0, bc);

    repeat (6) begin
      repeat (5) host_write(8'($urandom_range(0, 63)), 8'($urandom));
      f = $urandom_range(0, NE - 1);
      l = $urandom_range(f, NE - 1);
      stream(f, l, 2, 0, bc);
    end

    host_write(8'd0, 8'h01); host_write(8'd1, 8'h02);
    host_write(8'd2, 8'h04); host_write(8'd3, 8'h08);
    stream(0, 3, 0, 0, bc);
    chk("csum_busy_cycles", bc, nb - NE + 4);

    cfg_first = 8'd0; cfg_last = 8'd34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    config_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    config_rdy = 1'b0;
    @(negedge clk);
    chk("stall_beat", config_data, {8'd2, model[2]});
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", config_vld, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", config_data, 0);
    chk("arst_done", done, 0);
    for (int i = 0; i < NE; i++) model[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stream(0, 34, 0, 0, bc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
